// File: rtl/bist_lfsr_gen_if.sv
// rtl/bist_lfsr_gen_if.sv - control/status bundle between BIST controller and LFSR/MISR engine
interface bist_lfsr_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             lockup;

  modport master (
    output mode, start, num_patterns, seed_load, seed_in, data_in,
    input  q, count, busy, done, lockup
  );

  modport slave (
    input  mode, start, num_patterns, seed_load, seed_in, data_in,
    output q, count, busy, done, lockup
  );
endinterface

// File: rtl/bist_lfsr_gen.sv
// rtl/bist_lfsr_gen.sv - Galois LFSR pattern generator / MISR signature compactor with run counter
module bist_lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1C),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5),
  parameter int               CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  bist_lfsr_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] tap_mask;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] n_r;
  logic             mode_r;
  logic             accept_seed;
  logic             accept_start;
  logic             do_step;

  // Stage 0 never takes a tap: it receives the feedback bit directly.
  assign tap_mask  = {POLY[WIDTH-1:1], 1'b0};
  assign count_inc = count_r + CNT_W'(1);

  always_comb begin
    step_val = {q_r[WIDTH-2:0], q_r[WIDTH-1]} ^ (tap_mask & {WIDTH{q_r[WIDTH-1]}});
    if (mode_r) begin
      step_val = step_val ^ bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept_seed  = 1'b0;
    accept_start = 1'b0;
    do_step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        // Reseeding wins over a coincident start and always returns to IDLE.
        if (bus.seed_load) begin
          accept_seed = 1'b1;
          state_nxt   = IDLE;
        end else if (bus.start) begin
          accept_start = 1'b1;
          state_nxt    = (bus.num_patterns == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        do_step = 1'b1;
        if (count_inc == n_r) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= SEED;
      count_r <= '0;
      mode_r  <= 1'b0;
      n_r     <= '0;
    end else begin
      if (accept_seed) begin
        q_r <= bus.seed_in;
      end else if (do_step) begin
        q_r     <= step_val;
        count_r <= count_inc;
      end
      if (accept_start) begin
        mode_r  <= bus.mode;
        n_r     <= bus.num_patterns;
        count_r <= '0;
      end
    end
  end

  assign bus.q      = q_r;
  assign bus.count  = count_r;
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  // All-zero is a fixed point of the PRPG; in MISR mode data_in can still move it.
  assign bus.lockup = (q_r == '0) && !mode_r;

endmodule

// File: tb/tb_bist_lfsr_gen.sv
// tb/tb_bist_lfsr_gen.sv - directed vector bench for bist_lfsr_gen (8-bit default and 16-bit variant)
module tb_bist_lfsr_gen;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  bist_lfsr_gen_if #(.WIDTH(8),  .CNT_W(16)) bus  ();
  bist_lfsr_gen_if #(.WIDTH(16), .CNT_W(16)) bus2 ();

  bist_lfsr_gen #(.WIDTH(8), .POLY(8'h1C), .SEED(8'hA5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bist_lfsr_gen #(.WIDTH(16), .POLY(16'h002C), .SEED(16'h0001), .CNT_W(16)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  typedef struct {
    logic        start;
    logic        seed_load;
    logic        mode;
    logic [15:0] n;
    logic [7:0]  seed_in;
    logic [7:0]  data_in;
    logic [7:0]  q;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        lockup;
  } vec_t;

  vec_t tbl [16];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.seed_load = 1'b0; bus.mode = 1'b0;
    bus.num_patterns = '0; bus.seed_in = '0; bus.data_in = '0;
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] s, input logic misr, input logic [7:0] d);
    logic [7:0] r;
    r = {s[6:0], s[7]};
    if (s[7]) r = r ^ 8'h1C;
    if (misr) r = r ^ d;
    return r;
  endfunction

  initial begin
    int         busy_cnt;
    int         cyc;
    int         errs_q, errs_zero, errs_rep;
    logic [7:0] mq;
    bit         seen [256];

    //                 st sl md  N       seed   data   q      cnt     bsy dn lk
    tbl[0]  = '{1'b1,1'b0,1'b0,16'd2,  8'h00, 8'h00, 8'hA5, 16'd0, 1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h57, 16'd1, 1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'hAE, 16'd2, 1'b0,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd2, 1'b0,1'b0,1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b1,16'd3,  8'h00, 8'h01, 8'h00, 16'd0, 1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h01, 8'h01, 16'd1, 1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h01, 8'h03, 16'd2, 1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h01, 8'h07, 16'd3, 1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd3, 1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,16'd3,  8'h00, 8'h00, 8'h00, 16'd0, 1'b1,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd1, 1'b1,1'b0,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd2, 1'b1,1'b0,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd3, 1'b0,1'b1,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h00, 16'd0, 1'b0,1'b1,1'b1};
    tbl[14] = '{1'b1,1'b1,1'b1,16'd5,  8'h3C, 8'h00, 8'h3C, 16'd0, 1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,16'd0,  8'h00, 8'h00, 8'h3C, 16'd0, 1'b0,1'b0,1'b0};

    idle_inputs();
    bus2.start = 1'b0; bus2.seed_load = 1'b0; bus2.mode = 1'b0;
    bus2.num_patterns = '0; bus2.seed_in = '0; bus2.data_in = '0;
    rst = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset q",      bus.q,      8'hA5);
    chk("reset count",  bus.count,  16'd0);
    chk("reset busy",   bus.busy,   1'b0);
    chk("reset done",   bus.done,   1'b0);
    chk("reset lockup", bus.lockup, 1'b0);
    chk("reset q16",    bus2.q,     16'h0001);
    rst = 1'b0; rst2 = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      bus.start = tbl[i].start; bus.seed_load = tbl[i].seed_load; bus.mode = tbl[i].mode;
      bus.num_patterns = tbl[i].n; bus.seed_in = tbl[i].seed_in; bus.data_in = tbl[i].data_in;
      tick();
      chk($sformatf("vec%0d q", i),      bus.q,      tbl[i].q);
      chk($sformatf("vec%0d count", i),  bus.count,  tbl[i].cnt);
      chk($sformatf("vec%0d busy", i),   bus.busy,   tbl[i].busy);
      chk($sformatf("vec%0d done", i),   bus.done,   tbl[i].done);
      chk($sformatf("vec%0d lockup", i), bus.lockup, tbl[i].lockup);
    end

    // Full PRPG period from 0xA5
    idle_inputs();
    bus.seed_load = 1'b1; bus.seed_in = 8'hA5;
    tick();
    idle_inputs();
    bus.start = 1'b1; bus.num_patterns = 16'd255;
    tick();
    idle_inputs();
    chk("p255 first q", bus.q, 8'hA5);
    busy_cnt = bus.busy ? 1 : 0;
    mq = 8'hA5; errs_q = 0; errs_zero = 0; errs_rep = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    seen[8'hA5] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      mq = ref_step(mq, 1'b0, 8'h00);
      if (bus.q !== mq) errs_q++;
      if (bus.q == 8'h00 || bus.lockup !== 1'b0) errs_zero++;
      if (k < 255) begin
        if (seen[bus.q]) errs_rep++;
        seen[bus.q] = 1'b1;
      end
      if (bus.busy) busy_cnt++;
    end
    chk("p255 step errors",   errs_q,    0);
    chk("p255 zero/lockup",   errs_zero, 0);
    chk("p255 repeats",       errs_rep,  0);
    chk("p255 final q",       bus.q,     8'hA5);
    chk("p255 count",         bus.count, 16'd255);
    chk("p255 done",          bus.done,  1'b1);
    chk("p255 busy cycles",   busy_cnt,  255);

    // Mid-run disturbances must be ignored
    bus.seed_load = 1'b1; bus.seed_in = 8'hA5;
    tick();
    idle_inputs();
    bus.start = 1'b1; bus.num_patterns = 16'd100;
    tick();
    idle_inputs();
    busy_cnt = bus.busy ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b1; bus.seed_load = 1'b1; bus.seed_in = 8'h00;
    bus.mode = 1'b1; bus.num_patterns = 16'd5; bus.data_in = 8'hFF;
    tick();
    if (bus.busy) busy_cnt++;
    bus.start = 1'b0; bus.seed_load = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      tick();
      cyc++;
      if (bus.busy) busy_cnt++;
    end
    mq = 8'hA5;
    for (int k = 0; k < 100; k++) mq = ref_step(mq, 1'b0, 8'h00);
    chk("mid done reached",  bus.done,  1'b1);
    chk("mid busy cycles",   busy_cnt,  100);
    chk("mid count",         bus.count, 16'd100);
    chk("mid q",             bus.q,     mq);
    idle_inputs();

    // Asynchronous reset in the middle of a run
    bus.start = 1'b1; bus.num_patterns = 16'd100;
    tick();
    idle_inputs();
    cyc = 0;
    while (bus.count != 16'd50 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("rst run reached 50", bus.count, 16'd50);
    #2 rst = 1'b1;
    #1;
    chk("rst q",     bus.q,     8'hA5);
    chk("rst count", bus.count, 16'd0);
    chk("rst busy",  bus.busy,  1'b0);
    chk("rst done",  bus.done,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst stays idle", {bus.busy, bus.done, bus.q}, {1'b0, 1'b0, 8'hA5});

    // 16-bit maximal-length variant
    bus2.start = 1'b1; bus2.num_patterns = 16'hFFFF;
    tick();
    bus2.start = 1'b0; bus2.num_patterns = '0;
    busy_cnt = bus2.busy ? 1 : 0;
    cyc = 0;
    while (!bus2.done && cyc < 70000) begin
      tick();
      cyc++;
      if (bus2.busy) busy_cnt++;
    end
    chk("w16 done",        bus2.done,  1'b1);
    chk("w16 q",           bus2.q,     16'h0001);
    chk("w16 count",       bus2.count, 16'hFFFF);
    chk("w16 busy cycles", busy_cnt,   65535);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bist_lfsr_gen.md
# bist_lfsr_gen

Parametrised pattern-generation and signature-compaction engine for the BIST datapath. It implements a Galois LFSR of configurable width and feedback polynomial. It runs in PRPG mode, generating pseudo-random test patterns, or in MISR mode, compacting circuit-under-test responses into a signature. A programmable pattern counter and a small control FSM let the BIST controller start a run of N steps, wait for `done`, and read the final state.

## Interface
Parameters:
- `WIDTH`, 8: LFSR/MISR width in bits (≥ 3).
- `POLY`, 8'h1C: tap mask. Bit i (1 ≤ i ≤ WIDTH-1) set means stage i XORs feedback; bit 0 is ignored. The default gives x^8+x^4+x^3+x^2+1.
- `SEED`, 8'hA5: value loaded into `q` on reset (WIDTH bits).
- `CNT_W`, 16: width of the pattern counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `mode`, in, 1: 0 = PRPG, 1 = MISR; sampled on accepted `start`.
- `start`, in, 1: start a run; accepted in IDLE or DONE only.
- `num_patterns`, in, CNT_W: number of steps N; sampled on accepted `start`.
- `seed_load`, in, 1: load `seed_in` into `q`; accepted in IDLE or DONE only.
- `seed_in`, in, WIDTH: runtime seed.
- `data_in`, in, WIDTH: response word XORed in each RUN step in MISR mode.
- `q`, out, WIDTH: current LFSR/MISR state (registered).
- `count`, out, CNT_W: steps completed in the current/last run (registered).
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `lockup`, out, 1: combinational; high when `q == 0` and latched mode is PRPG.

## Operation
- Step function, with fb = q[WIDTH-1]:
  - next[0] = fb.
  - next[i] = q[i-1] ^ (POLY[i] & fb) for i ≥ 1.
  - MISR mode additionally XORs `data_in` into all bits: next ^= data_in.
- FSM states: IDLE, RUN, DONE. Reset values: state = IDLE, `q` = SEED, `count` = 0, latched mode = PRPG, `busy` = 0, `done` = 0.
- IDLE / DONE:
  - `q` holds.
  - `seed_load` has priority over `start` when both are high.
    - It loads `q` ← `seed_in` and sets state to IDLE, so `done` drops.
    - The coincident `start` is ignored.
  - `start` (without `seed_load`):
    - Latches `mode` and `num_patterns`, and clears `count` to 0.
    - If N = 0: state goes to DONE immediately, with no step taken.
    - Otherwise: state goes to RUN.
    - `q` is not reseeded; restarting from DONE continues from the current state.
- RUN:
  - Every cycle: `q` ← step(`q`), `count` ← `count` + 1.
  - When `count` + 1 == N: state goes to DONE.
  - `start`, `seed_load`, and changes to `mode` / `num_patterns` are ignored.
- `count` never wraps within a run (max N = 2^CNT_W − 1).
- Lockup: in PRPG mode, a zero state is a fixed point. `lockup` flags it; the block does not self-recover, and the controller must reseed. The zero state is legal in MISR mode; `lockup` stays 0.
- Reset mid-run: aborts immediately to IDLE with `q` = SEED and `count` = 0. No partial `done`.

## Timing
- `start` sampled at edge E0 (N ≥ 1): after E0, `busy` = 1, `count` = 0, and `q` is unchanged.
- Edges E1..EN each perform one step. After EN: `busy` = 0, `done` = 1, `count` = N, and `q` is the final pattern/signature.
- `busy` is high for exactly N cycles.
- Start-to-done latency is N+1 edges. For N = 0, `done` is high after E0.
- MISR: `data_in` is sampled at E1..EN. The response for step k must be stable before edge Ek.
- PRPG: the pattern presented to the CUT during cycle k (between E(k−1) and Ek) is the `q` value visible in that cycle.
- `done` remains high until the next accepted `start` or `seed_load`.
- `lockup` follows `q` with combinational delay only.

## Test plan
- Reset, then PRPG with N = 2 (defaults): `q` = 0xA5 → 0x57 after E1 → 0xAE after E2. Then `done` = 1, `count` = 2, `busy` high exactly 2 cycles.
- PRPG with N = 255 from 0xA5: `q` returns to 0xA5 at `done`. No intermediate state repeats or equals 0. `lockup` never asserts.
- `seed_load` with `seed_in` = 0x00, MISR, N = 3, `data_in` = 0x01 constant: `q` = 0x01, 0x03, 0x07, with `done` after the 3rd step. Repeat in PRPG from 0x00: `q` stays 0 and `lockup` = 1.
- `start` with N = 0: `done` = 1 the cycle after `start`, with `q` and `count` = 0 unchanged. Then `seed_load` and `start` high together: `q` = `seed_in`, state IDLE, no run.
- Mid-run (N = 100, after 10 steps): pulse `start`, `seed_load`, and toggle `mode`; all are ignored, and `done` arrives after exactly 100 steps. A second run asserts `rst` at step 50: the block is immediately IDLE with `q` = 0xA5, `count` = 0, `done` = 0.
- Parameter variant WIDTH = 16, POLY = 16'h002C (x^16+x^5+x^3+x^2+1), SEED = 16'h0001, N = 65535: `q` returns to 0x0001 at `done`, and `count` = 65535.
